// File: rtl/dm_abstract_cmd.sv
// dm_abstract_cmd
//   Debug Module front end for a single-hart core. Decodes DMI accesses to
//   data0, dmcontrol, dmstatus, abstractcs and command. Drives the halt/resume
//   handshake toward the core debug FSM, and runs Access Register abstract
//   commands over the dbg_ar_* strobe interface.
//
//   state  | meaning
//   IDLE   | no abstract command in flight (busy = 0)
//   ACCESS | one-cycle dbg_ar_en_o strobe with wr/ad/do driven
//   WAIT   | read in flight; capture dbg_ar_di_i into data0 when count hits 0
//
// Ports
//   clk_i, reset_i                 clock, async active-high reset
//   dmi_req_*                      DMI request (valid/ready, addr, op, data)
//   dmi_rsp_*                      DMI response (valid/ready, data, resp)
//   core_halted_i/core_running_i   core debug status levels
//   core_resumeack_i               core acknowledges a resume request
//   dbg_haltreq_o/dbg_resumereq_o  halt level / resume request
//   dbg_ar_*                       abstract register access interface
module dm_abstract_cmd #(
    parameter int unsigned AR_LATENCY = 1,
    parameter int unsigned ABITS      = 7
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             dmi_req_valid_i,
    output logic             dmi_req_ready_o,
    input  logic [ABITS-1:0] dmi_req_addr_i,
    input  logic [1:0]       dmi_req_op_i,
    input  logic [31:0]      dmi_req_data_i,
    output logic             dmi_rsp_valid_o,
    input  logic             dmi_rsp_ready_i,
    output logic [31:0]      dmi_rsp_data_o,
    output logic [1:0]       dmi_rsp_resp_o,
    input  logic             core_halted_i,
    input  logic             core_running_i,
    input  logic             core_resumeack_i,
    output logic             dbg_haltreq_o,
    output logic             dbg_resumereq_o,
    output logic             dbg_ar_en_o,
    output logic             dbg_ar_wr_o,
    output logic [15:0]      dbg_ar_ad_o,
    output logic [31:0]      dbg_ar_do_o,
    input  logic [31:0]      dbg_ar_di_i
);

    localparam logic [ABITS-1:0] A_DATA0 = ABITS'(32'h04);
    localparam logic [ABITS-1:0] A_DMCTL = ABITS'(32'h10);
    localparam logic [ABITS-1:0] A_DMSTS = ABITS'(32'h11);
    localparam logic [ABITS-1:0] A_ACS   = ABITS'(32'h16);
    localparam logic [ABITS-1:0] A_CMD   = ABITS'(32'h17);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT} state_t;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic [31:0] data0_q;
    logic        dmactive_q;
    logic        haltreq_q;
    logic        resume_pending_q;
    logic        resumeack_q;
    logic [2:0]  cmderr_q;
    logic        ar_en_q;
    logic        ar_wr_q;
    logic [15:0] ar_ad_q;
    logic [31:0] ar_do_q;

    logic        accept, is_rd, is_wr, busy;
    logic        wr_data0, wr_dmctl, wr_acs, wr_cmd;
    logic [31:0] wdata;
    logic [31:0] rdata_d;

    assign accept   = dmi_req_valid_i & ~rsp_valid_q;
    assign is_rd    = accept & (dmi_req_op_i == 2'd1);
    assign is_wr    = accept & (dmi_req_op_i == 2'd2);
    assign busy     = (state_q != ST_IDLE);
    assign wdata    = dmi_req_data_i;
    assign wr_data0 = is_wr & (dmi_req_addr_i == A_DATA0);
    assign wr_dmctl = is_wr & (dmi_req_addr_i == A_DMCTL);
    assign wr_acs   = is_wr & (dmi_req_addr_i == A_ACS);
    assign wr_cmd   = is_wr & (dmi_req_addr_i == A_CMD);

    always_comb begin
        rdata_d = 32'h0;
        if (is_rd) begin
            unique case (dmi_req_addr_i)
                A_DATA0: rdata_d = data0_q;
                A_DMCTL: rdata_d = {haltreq_q, 30'h0, dmactive_q};
                A_DMSTS: rdata_d = {14'h0, {2{resumeack_q}}, 4'h0,
                                    {2{core_running_i}}, {2{core_halted_i}},
                                    1'b1, 3'h0, 4'd2};
                A_ACS:   rdata_d = {19'h0, busy, 1'b0, cmderr_q, 8'h01};
                default: rdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q          <= ST_IDLE;
            cnt_q            <= 3'd0;
            rsp_valid_q      <= 1'b0;
            rsp_data_q       <= 32'h0;
            data0_q          <= 32'h0;
            dmactive_q       <= 1'b0;
            haltreq_q        <= 1'b0;
            resume_pending_q <= 1'b0;
            resumeack_q      <= 1'b0;
            cmderr_q         <= 3'd0;
            ar_en_q          <= 1'b0;
            ar_wr_q          <= 1'b0;
            ar_ad_q          <= 16'h0;
            ar_do_q          <= 32'h0;
        end else begin
            if (accept) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= rdata_d;
            end else if (rsp_valid_q && dmi_rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
                rsp_data_q  <= 32'h0;
            end

            if (resume_pending_q && core_resumeack_i) begin
                resumeack_q      <= 1'b1;
                resume_pending_q <= 1'b0;
            end

            // Strobe outputs default to zero; only a command launch raises them.
            ar_en_q <= 1'b0;
            ar_wr_q <= 1'b0;
            ar_ad_q <= 16'h0;
            ar_do_q <= 32'h0;

            unique case (state_q)
                ST_ACCESS: begin
                    if (ar_wr_q) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_WAIT;
                        cnt_q   <= 3'(AR_LATENCY - 1);
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        data0_q <= dbg_ar_di_i;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: ;
            endcase

            if (dmactive_q) begin
                if (wr_data0 || wr_acs) begin
                    if (busy) begin
                        if (cmderr_q == 3'd0) cmderr_q <= 3'd1;
                    end else if (wr_data0) begin
                        data0_q <= wdata;
                    end else begin
                        cmderr_q <= cmderr_q & ~wdata[10:8];
                    end
                end
                if (wr_dmctl) begin
                    haltreq_q <= wdata[31];
                    if (wdata[30] && !wdata[31] && core_halted_i) begin
                        resumeack_q      <= 1'b0;
                        resume_pending_q <= 1'b1;
                    end
                end
                if (wr_cmd) begin
                    if (busy) begin
                        cmderr_q <= 3'd1;
                    end else if (cmderr_q != 3'd0) begin
                        // sticky error blocks new commands until cleared
                    end else if ((wdata[31:24] != 8'd0) || (wdata[22:20] != 3'd2) || wdata[18]) begin
                        cmderr_q <= 3'd2;
                    end else if (!core_halted_i) begin
                        cmderr_q <= 3'd4;
                    end else if (wdata[17]) begin
                        state_q <= ST_ACCESS;
                        ar_en_q <= 1'b1;
                        ar_wr_q <= wdata[16];
                        ar_ad_q <= wdata[15:0];
                        ar_do_q <= data0_q;
                    end
                end
            end

            if (wr_dmctl) dmactive_q <= wdata[0];

            // Inactive DM: hold everything in its quiescent state and drop
            // any in-flight read so stale data never lands in data0.
            if (!dmactive_q || (wr_dmctl && !wdata[0])) begin
                haltreq_q        <= 1'b0;
                resume_pending_q <= 1'b0;
                cmderr_q         <= 3'd0;
                data0_q          <= 32'h0;
                state_q          <= ST_IDLE;
                cnt_q            <= 3'd0;
                ar_en_q          <= 1'b0;
                ar_wr_q          <= 1'b0;
                ar_ad_q          <= 16'h0;
                ar_do_q          <= 32'h0;
            end
        end
    end

    assign dmi_req_ready_o = ~rsp_valid_q;
    assign dmi_rsp_valid_o = rsp_valid_q;
    assign dmi_rsp_data_o  = rsp_data_q;
    assign dmi_rsp_resp_o  = 2'd0;
    assign dbg_haltreq_o   = haltreq_q & dmactive_q;
    assign dbg_resumereq_o = resume_pending_q;
    assign dbg_ar_en_o     = ar_en_q;
    assign dbg_ar_wr_o     = ar_wr_q;
    assign dbg_ar_ad_o     = ar_ad_q;
    assign dbg_ar_do_o     = ar_do_q;

endmodule

// File: tb/tb_dm_abstract_cmd.sv
// Directed bench for dm_abstract_cmd with a read-latency-2 register responder.
module tb_dm_abstract_cmd;
    localparam int TB_LAT = 2;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        dmi_req_valid_i = 1'b0;
    logic        dmi_req_ready_o;
    logic [6:0]  dmi_req_addr_i = 7'h0;
    logic [1:0]  dmi_req_op_i = 2'd0;
    logic [31:0] dmi_req_data_i = 32'h0;
    logic        dmi_rsp_valid_o;
    logic        dmi_rsp_ready_i = 1'b1;
    logic [31:0] dmi_rsp_data_o;
    logic [1:0]  dmi_rsp_resp_o;
    logic        core_halted_i = 1'b0;
    logic        core_running_i = 1'b0;
    logic        core_resumeack_i = 1'b0;
    logic        dbg_haltreq_o;
    logic        dbg_resumereq_o;
    logic        dbg_ar_en_o;
    logic        dbg_ar_wr_o;
    logic [15:0] dbg_ar_ad_o;
    logic [31:0] dbg_ar_do_o;
    logic [31:0] dbg_ar_di_i;

    dm_abstract_cmd #(.AR_LATENCY(TB_LAT), .ABITS(7)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .dmi_req_valid_i(dmi_req_valid_i), .dmi_req_ready_o(dmi_req_ready_o),
        .dmi_req_addr_i(dmi_req_addr_i), .dmi_req_op_i(dmi_req_op_i),
        .dmi_req_data_i(dmi_req_data_i), .dmi_rsp_valid_o(dmi_rsp_valid_o),
        .dmi_rsp_ready_i(dmi_rsp_ready_i), .dmi_rsp_data_o(dmi_rsp_data_o),
        .dmi_rsp_resp_o(dmi_rsp_resp_o), .core_halted_i(core_halted_i),
        .core_running_i(core_running_i), .core_resumeack_i(core_resumeack_i),
        .dbg_haltreq_o(dbg_haltreq_o), .dbg_resumereq_o(dbg_resumereq_o),
        .dbg_ar_en_o(dbg_ar_en_o), .dbg_ar_wr_o(dbg_ar_wr_o),
        .dbg_ar_ad_o(dbg_ar_ad_o), .dbg_ar_do_o(dbg_ar_do_o),
        .dbg_ar_di_i(dbg_ar_di_i)
    );

    always #5 clk_i = ~clk_i;

    // Register-file responder: read data is valid exactly TB_LAT cycles after the strobe.
    logic [31:0]       rd_val = 32'h0;
    logic [TB_LAT-1:0] pipe = '0;
    always @(posedge clk_i) pipe <= {pipe[TB_LAT-2:0], dbg_ar_en_o & ~dbg_ar_wr_o};
    assign dbg_ar_di_i = pipe[TB_LAT-1] ? rd_val : 32'h0badf00d;

    // Strobe monitor.
    int          en_cnt = 0;
    int          idle_viol = 0;
    logic        last_wr = 1'b0;
    logic [15:0] last_ad = 16'h0;
    logic [31:0] last_do = 32'h0;
    always @(negedge clk_i) begin
        if (dbg_ar_en_o) begin
            en_cnt  = en_cnt + 1;
            last_wr = dbg_ar_wr_o;
            last_ad = dbg_ar_ad_o;
            last_do = dbg_ar_do_o;
        end else if (dbg_ar_wr_o || dbg_ar_ad_o != 16'h0 || dbg_ar_do_o != 32'h0) begin
            idle_viol = idle_viol + 1;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic dmi(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                       output logic [31:0] r);
        int n;
        @(negedge clk_i);
        n = 0;
        while (!dmi_req_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 20) chk("req_ready_timeout", {31'h0, dmi_req_ready_o}, 32'h1);
        dmi_req_valid_i = 1'b1;
        dmi_req_addr_i  = a;
        dmi_req_op_i    = op;
        dmi_req_data_i  = d;
        @(posedge clk_i);
        #1;
        dmi_req_valid_i = 1'b0;
        dmi_req_op_i    = 2'd0;
        r = dmi_rsp_data_o;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        logic [31:0] r;
        dmi(a, 2'd2, d, r);
    endtask

    task automatic rd(input string tag, input logic [6:0] a, input logic [31:0] exp);
        logic [31:0] r;
        dmi(a, 2'd1, 32'h0, r);
        chk(tag, r, exp);
    endtask

    initial begin
        int e0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_haltreq", {31'h0, dbg_haltreq_o}, 32'h0);
        chk("rst_en", {31'h0, dbg_ar_en_o}, 32'h0);
        @(negedge clk_i);
        reset_i = 1'b0;
        chk("rst_rsp_valid", {31'h0, dmi_rsp_valid_o}, 32'h0);
        chk("rst_req_ready", {31'h0, dmi_req_ready_o}, 32'h1);
        chk("rst_resumereq", {31'h0, dbg_resumereq_o}, 32'h0);
        rd("rst_dmcontrol", 7'h10, 32'h0);
        rd("rst_dmstatus", 7'h11, 32'h00000082);
        rd("rst_abstractcs", 7'h16, 32'h00000001);
        wr(7'h04, 32'h55);
        rd("inactive_data0_drop", 7'h04, 32'h0);

        // 1: activate and halt
        wr(7'h10, 32'h1);
        wr(7'h10, 32'h80000001);
        chk("t1_haltreq", {31'h0, dbg_haltreq_o}, 32'h1);
        core_halted_i = 1'b1;
        rd("t1_dmstatus", 7'h11, 32'h00000382);
        rd("t1_dmcontrol", 7'h10, 32'h80000001);
        rd("t1_unmapped", 7'h20, 32'h0);
        chk("t1_resp", {30'h0, dmi_rsp_resp_o}, 32'h0);

        // 2: register write to dpc
        wr(7'h04, 32'h80000040);
        e0 = en_cnt;
        wr(7'h17, 32'h002307b1);
        chk("t2_en_pulses", en_cnt - e0, 1);
        chk("t2_wr", {31'h0, last_wr}, 32'h1);
        chk("t2_ad", {16'h0, last_ad}, 32'h000007b1);
        chk("t2_do", last_do, 32'h80000040);
        rd("t2_abstractcs", 7'h16, 32'h00000001);
        rd("t2_command_reads0", 7'h17, 32'h0);

        // 3: GPR read with latency 2
        rd_val = 32'hdeadbeef;
        wr(7'h17, 32'h00221005);
        rd("t3_busy", 7'h16, 32'h00001001);
        rd("t3_idle", 7'h16, 32'h00000001);
        rd("t3_data0", 7'h04, 32'hdeadbeef);
        chk("t3_wr", {31'h0, last_wr}, 32'h0);
        chk("t3_ad", {16'h0, last_ad}, 32'h00001005);

        // 4: command while busy, sticky cmderr, W1C clear
        rd_val = 32'h0000abcd;
        wr(7'h17, 32'h00221002);
        wr(7'h17, 32'h002307b1);
        e0 = en_cnt;
        wr(7'h17, 32'h002307b1);
        chk("t4_ignored_no_en", en_cnt - e0, 0);
        rd("t4_cmderr1", 7'h16, 32'h00000101);
        wr(7'h16, 32'h00000700);
        rd("t4_cleared", 7'h16, 32'h00000001);
        rd("t4_data0", 7'h04, 32'h0000abcd);
        rd_val = 32'h11112222;
        wr(7'h17, 32'h00221003);
        wr(7'h04, 32'h00000099);
        rd("t4_data0_busy_err", 7'h16, 32'h00000101);
        rd("t4_data0_kept", 7'h04, 32'h11112222);
        wr(7'h16, 32'h00000700);

        // 5: running core and bad aarsize
        core_halted_i  = 1'b0;
        core_running_i = 1'b1;
        e0 = en_cnt;
        wr(7'h17, 32'h00230000);
        rd("t5_cmderr4", 7'h16, 32'h00000401);
        chk("t5_no_en", en_cnt - e0, 0);
        wr(7'h16, 32'h00000700);
        wr(7'h17, 32'h00330000);
        rd("t5_cmderr2", 7'h16, 32'h00000201);
        wr(7'h16, 32'h00000700);
        rd("t5_dmstatus", 7'h11, 32'h00000c82);

        // 6: resume handshake
        core_halted_i  = 1'b1;
        core_running_i = 1'b0;
        wr(7'h10, 32'h40000001);
        chk("t6_resumereq", {31'h0, dbg_resumereq_o}, 32'h1);
        repeat (3) @(posedge clk_i);
        #1;
        chk("t6_resumereq_held", {31'h0, dbg_resumereq_o}, 32'h1);
        rd("t6_ack_clear", 7'h11, 32'h00000382);
        @(negedge clk_i);
        core_resumeack_i = 1'b1;
        core_halted_i    = 1'b0;
        core_running_i   = 1'b1;
        @(posedge clk_i);
        #1;
        chk("t6_resumereq_drop", {31'h0, dbg_resumereq_o}, 32'h0);
        @(negedge clk_i);
        core_resumeack_i = 1'b0;
        rd("t6_anyresumeack", 7'h11, 32'h00030c82);
        chk("t6_haltreq0", {31'h0, dbg_haltreq_o}, 32'h0);
        core_halted_i  = 1'b1;
        core_running_i = 1'b0;
        wr(7'h10, 32'hc0000001);
        chk("t6_resume_w_halt_ign", {31'h0, dbg_resumereq_o}, 32'h0);
        chk("t6_haltreq1", {31'h0, dbg_haltreq_o}, 32'h1);
        core_halted_i = 1'b0;
        wr(7'h10, 32'h40000001);
        chk("t6_resume_running_ign", {31'h0, dbg_resumereq_o}, 32'h0);
        core_halted_i = 1'b1;

        // 6b: deactivate mid-read
        wr(7'h04, 32'h00001234);
        rd_val = 32'h5a5a5a5a;
        wr(7'h17, 32'h00221000);
        wr(7'h10, 32'h00000000);
        rd("t6_data0_cleared", 7'h04, 32'h0);
        rd("t6_fsm_idle", 7'h16, 32'h00000001);
        chk("t6_haltreq_off", {31'h0, dbg_haltreq_o}, 32'h0);
        wr(7'h10, 32'h00000001);
        rd("t6_data0_after", 7'h04, 32'h0);
        rd("t6_dmcontrol", 7'h10, 32'h00000001);

        chk("ar_outputs_zero_when_idle", idle_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
